apb_slave_regbank: RTL

- APB completer that sits directly downstream of the AHB-to-APB bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA transfers.
- Holds a bank of NUM_REGS word registers, returns PRDATA, and inserts WAIT_STATES wait cycles per transfer via PREADY.
- Flags decode and protocol errors on PSLVERR and counts them.
- Register 0 drives a control output to the peripheral.

---
 rtl/apb_slave_regbank_if.sv | 26 ++
 rtl/apb_slave_regbank.sv | 116 +++++++++++
 2 files changed

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between a requester (bridge) and the register bank.
//   master : drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave  : the reverse
interface apb_slave_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer holding NUM_REGS word registers.
//   PCLK      : clock, rising edge
//   PRESET    : asynchronous active-high reset
//   apb       : APB slave port (PSEL/PENABLE/PADDR/PWRITE/PWDATA in,
//               PRDATA/PREADY/PSLVERR out)
//   REG0_OUT  : register 0 contents, drives the peripheral
//   ERR_COUNT : saturating count of error responses (decode, protocol, abort)
// Every access phase is stretched by WAIT_STATES cycles. Decode errors are
// latched at setup and reported on completion; an access strobe without a
// preceding setup is answered with an immediate error.
module apb_slave_regbank #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_slave_regbank_if.slave    apb,
  output logic [DATA_WIDTH-1:0] REG0_OUT,
  output logic [7:0]            ERR_COUNT
);

  localparam int                    IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NREGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WS      = 4'(WAIT_STATES);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

  state_e                             state_q, state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [DATA_WIDTH-1:0]              prdata_q;
  logic [3:0]                         cnt_q;
  logic                               err_q;
  logic [IW-1:0]                      idx_q;
  logic [7:0]                         errcnt_q;

  logic          setup, access, dec_err;
  logic [IW-1:0] idx;
  logic          proto_err, done, abort, err_inc;

  assign setup   = apb.PSEL & ~apb.PENABLE;
  assign access  = apb.PSEL &  apb.PENABLE;
  assign dec_err = (apb.PADDR[1:0] != 2'b00) ||
                   ({2'b00, apb.PADDR[ADDR_WIDTH-1:2]} >= NREGS_A);
  // Truncated index; only used when dec_err is clear, so it is in range.
  assign idx     = apb.PADDR[IW+1:2];

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (setup) state_d = ST_ACCESS;
      ST_ACCESS: if (done || abort) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs / events. Response is gated by reset so a reset landing
  // mid-transfer drops PREADY at once even if the bus is still strobing.
  always_comb begin
    proto_err   = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    case (state_q)
      ST_IDLE:   proto_err = access;
      ST_ACCESS: begin
        done  = access && (cnt_q == WS);
        abort = ~access;
      end
      default: ;
    endcase
    if (!PRESET) begin
      apb.PREADY  = proto_err | done;
      apb.PSLVERR = proto_err | (done & err_q);
    end
  end

  assign err_inc = proto_err | (done & err_q) | abort;

  // Datapath
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      regs_q   <= '0;
      prdata_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      errcnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE && setup) begin
        cnt_q <= '0;
        err_q <= dec_err;
        idx_q <= idx;
        if (!apb.PWRITE) prdata_q <= dec_err ? '0 : regs_q[idx];
      end
      if (state_q == ST_ACCESS && access && !done) cnt_q <= cnt_q + 4'd1;
      // Write data is taken from the completion cycle.
      if (done && apb.PWRITE && !err_q) regs_q[idx_q] <= apb.PWDATA;
      if (err_inc && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign REG0_OUT   = regs_q[0];
  assign ERR_COUNT  = errcnt_q;

endmodule
